// File: rtl/stdaes_inv_round_seq.sv
`timescale 1ns/1ps
// stdaes_inv_round_seq -- iterative AES-128 inverse cipher sequencer (one block at a time).
// Latency: 11 KEY + 10 SUB cycles, so done is high in the 22nd cycle after the start edge with zero-wait handshakes.
// Backpressure: key_req/sub_req are held until key_vld/sub_ack, and every wait cycle adds one cycle of latency.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start, din, ready     block input; din is accepted on start while ready=1
//   done, dout            one-cycle done pulse; dout holds the plaintext until the next block finishes or reset
//   key_req, key_round,   round-key fetch; key_round counts NR down to 0
//   key_vld, key_data
//   sub_req, sub_din,     InvSubBytes offload; sub_din = InvShiftRows(state)
//   sub_ack, sub_dout
// Option: define STDAES_INV_ROUND_OUT_EN to add round_vld/round_st, which expose the post-InvSubBytes
//   state of every round. Without the macro the ports and their registers are absent.
module stdaes_inv_round_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] din,
  output logic         ready,
  output logic         done,
  output logic [127:0] dout,
  output logic         key_req,
  output logic [3:0]   key_round,
  input  logic         key_vld,
  input  logic [127:0] key_data,
  output logic         sub_req,
  output logic [127:0] sub_din,
  input  logic         sub_ack,
  input  logic [127:0] sub_dout
`ifdef STDAES_INV_ROUND_OUT_EN
  ,
  output logic         round_vld,
  output logic [127:0] round_st
`endif
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEY  = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state, state_nxt;
  logic [127:0] st;
  logic [3:0]   rnd;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, polynomial 0x11b. The InvMixColumns constants are built
  // from three chained xtime stages: 9 = 8+1, b = 8+2+1, d = 8+4+1, e = 8+4+2.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0]  x1 [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      x1[r] = w[31-8*r -: 8];
      x2[r] = xt(x1[r]);
      x4[r] = xt(x2[r]);
      x8[r] = xt(x4[r]);
      m9[r] = x8[r] ^ x1[r];
      mb[r] = x8[r] ^ x2[r] ^ x1[r];
      md[r] = x8[r] ^ x4[r] ^ x1[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] a);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      res[127-32*c -: 32] = inv_mix_col(a[127-32*c -: 32]);
    end
    return res;
  endfunction

  // Row r of output column c comes from input column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] a);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-32*c-8*r -: 8] = a[127-32*((c+4-r)%4)-8*r -: 8];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    key_req   = 1'b0;
    sub_req   = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_KEY;
      end
      S_KEY: begin
        key_req = 1'b1;
        // Round 0 is the last key; there is no substitution after it.
        if (key_vld) state_nxt = (rnd == 4'd0) ? S_DONE : S_SUB;
      end
      S_SUB: begin
        sub_req = 1'b1;
        if (sub_ack) state_nxt = S_KEY;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign key_round = rnd;
  assign sub_din   = inv_shift_rows(st);

  // ---------------------------------------------------------------------------
  // Datapath: state, round counter and result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= '0;
      rnd  <= '0;
      dout <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            st  <= din;
            rnd <= NR_L;
          end
        end
        S_KEY: begin
          if (key_vld) begin
            // First key is a plain whitening add; middle rounds fold
            // InvMixColumns in after the key add; the last key lands in dout.
            if (rnd == NR_L) begin
              st <= st ^ key_data;
            end else if (rnd != 4'd0) begin
              st <= inv_mix(st ^ key_data);
            end else begin
              dout <= st ^ key_data;
            end
          end
        end
        S_SUB: begin
          if (sub_ack) begin
            st  <= sub_dout;
            rnd <= rnd - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STDAES_INV_ROUND_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_vld <= 1'b0;
      round_st  <= '0;
    end else begin
      round_vld <= (state == S_SUB) && sub_ack;
      if ((state == S_SUB) && sub_ack) round_st <= sub_dout;
    end
  end
`endif

endmodule

// File: tb/tb_stdaes_inv_round_seq.sv
`timescale 1ns/1ps
// Self-checking bench for stdaes_inv_round_seq. Acts as both the key store and
// the InvSubBytes unit, and compares every completed block against a textbook
// AES inverse-cipher model built from generated S-box tables.
module tb_stdaes_inv_round_seq;

  localparam int NR = 10;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk, rst, start, key_vld, sub_ack;
  logic [127:0] din, key_data, sub_dout;
  logic         ready, done, key_req, sub_req;
  logic [127:0] dout, sub_din;
  logic [3:0]   key_round;
`ifdef STDAES_INV_ROUND_OUT_EN
  logic         round_vld;
  logic [127:0] round_st;
`endif

  stdaes_inv_round_seq #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .ready(ready), .done(done), .dout(dout),
    .key_req(key_req), .key_round(key_round), .key_vld(key_vld), .key_data(key_data),
    .sub_req(sub_req), .sub_din(sub_din), .sub_ack(sub_ack), .sub_dout(sub_dout)
`ifdef STDAES_INV_ROUND_OUT_EN
    , .round_vld(round_vld), .round_st(round_st)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference tables and model
  // ---------------------------------------------------------------------------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [2][11];
  logic [127:0] m_pt;
  logic [127:0] m_tr  [10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] av, inv, s;
    for (int a = 0; a < 256; a++) begin
      av  = 8'(a);
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = av;
    end
  endtask

  task automatic expand(input int ks, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[ks][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Byte i = 4*col + row sits at bits [127-8i -: 8].
  function automatic logic [127:0] m_isr(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+4-r)%4)+r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] m_isub(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = isbox[x[127-8*i -: 8]];
    return y;
  endfunction

  function automatic logic [127:0] m_imix(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a [4];
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = x[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = gmul(8'h0e, a[r]) ^ gmul(8'h0b, a[(r+1)%4]) ^
                                gmul(8'h0d, a[(r+2)%4]) ^ gmul(8'h09, a[(r+3)%4]);
    end
    return y;
  endfunction

  // FIPS-197 inverse cipher; m_tr holds the state after each InvSubBytes.
  task automatic model_dec(input logic [127:0] ct, input int ks);
    logic [127:0] s;
    s = ct ^ rk[ks][10];
    for (int rd = 9; rd >= 1; rd--) begin
      s = m_isub(m_isr(s));
      m_tr[9-rd] = s;
      s = m_imix(s ^ rk[ks][rd]);
    end
    s = m_isub(m_isr(s));
    m_tr[9] = s;
    m_pt = s ^ rk[ks][0];
  endtask

  // ---------------------------------------------------------------------------
  // Key store and InvSubBytes responders (hs_mode 0: tied high, 1: random 0-5 waits)
  // ---------------------------------------------------------------------------
  int hs_mode = 0;
  int key_sel = 0;
  int waits   = 0;

  initial begin
    int kw, sw;
    kw = 0; sw = 0;
    key_vld = 1'b0; sub_ack = 1'b0; key_data = '0; sub_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (hs_mode == 0) begin
        key_vld = 1'b1;
        sub_ack = 1'b1;
      end else begin
        if (key_req) begin
          if (kw == 0) key_vld = 1'b1;
          else begin key_vld = 1'b0; kw--; waits++; end
        end else begin
          key_vld = 1'b0;
          kw = int'($urandom_range(0, 5));
        end
        if (sub_req) begin
          if (sw == 0) sub_ack = 1'b1;
          else begin sub_ack = 1'b0; sw--; waits++; end
        end else begin
          sub_ack = 1'b0;
          sw = int'($urandom_range(0, 5));
        end
      end
      key_data = (key_round <= 4'd10) ? rk[key_sel][key_round] : '0;
      sub_dout = m_isub(sub_din);
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: scoreboard of accepted blocks, checked at every negedge
  // ---------------------------------------------------------------------------
  logic [127:0] pt_q [$];
  logic [127:0] tr_q [$];
  logic [127:0] last_dout;
  int exp_round, kacks, rvc;

  initial begin
    last_dout = '0; exp_round = 0; kacks = 0; rvc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pt_q.delete(); tr_q.delete();
        last_dout = '0; kacks = 0; rvc = 0; exp_round = 0;
      end else begin
        chk("req_exclusive", {127'd0, key_req & sub_req}, 128'd0);
        if (pt_q.size() > 0) chk("ready_while_busy", {127'd0, ready}, 128'd0);
        if (key_req && key_vld) begin
          if (exp_round >= 0) chk("key_round_seq", {124'd0, key_round}, 128'(exp_round));
          else chk("extra_key_fetch", {127'd0, key_req}, 128'd0);
          exp_round--;
          kacks++;
        end
`ifdef STDAES_INV_ROUND_OUT_EN
        if (round_vld) begin
          if (tr_q.size() > 0) begin
            chk("round_st", round_st, tr_q.pop_front());
            rvc++;
          end else chk("spurious_round_vld", {127'd0, round_vld}, 128'd0);
        end
`endif
        if (done) begin
          if (pt_q.size() == 0) chk("spurious_done", {127'd0, done}, 128'd0);
          else begin
            last_dout = pt_q.pop_front();
            chk("dout_model", dout, last_dout);
            chk("key_fetches", 128'(kacks), 128'(NR + 1));
`ifdef STDAES_INV_ROUND_OUT_EN
            chk("round_vld_count", 128'(rvc), 128'(NR));
`endif
          end
        end else begin
          chk("dout_held", dout, last_dout);
        end
        if (start && ready) begin
          model_dec(din, key_sel);
          pt_q.push_back(m_pt);
          for (int i = 0; i < 10; i++) tr_q.push_back(m_tr[i]);
          exp_round = NR; kacks = 0; rvc = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Starts one block from a posedge+#1 point and returns in the IDLE cycle
  // after done (so an immediate next call is a back-to-back start).
  task automatic run_block(input string tag, input logic [127:0] ct, input int ks,
                           input bit spam, input logic [127:0] exp_pt);
    int cyc;
    key_sel = ks;
    din     = ct;
    waits   = 0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 2000) begin
      if (spam) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {127'd0, done}, 128'd1);
    chk({tag, "_latency"}, 128'(cyc), 128'(22 + waits));
    chk({tag, "_dout"}, dout, exp_pt);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, {127'd0, done}, 128'd0);
    chk({tag, "_ready_after"}, {127'd0, ready}, 128'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; din = '0;
    build_sbox();
    expand(0, C1_KEY);
    expand(1, B_KEY);

    // Pins on the model itself.
    chk("pin_sbox_53", {120'd0, sbox[8'h53]}, 128'hed);
    chk("pin_isbox_00", {120'd0, isbox[8'h00]}, 128'h52);
    chk("pin_rk10_c1", rk[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("pin_rk10_b", rk[1][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    model_dec(C1_CT, 0);
    chk("pin_model_c1", m_pt, C1_PT);
    chk("pin_trace_first", m_tr[0], 128'hbd6e7c3df2b5779e0b61216e8b10b689);
    chk("pin_trace_last", m_tr[9], 128'h00102030405060708090a0b0c0d0e0f0);
    model_dec(B_CT, 1);
    chk("pin_model_b", m_pt, B_PT);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {127'd0, ready}, 128'd1);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_key_req", {127'd0, key_req}, 128'd0);
    chk("rst_sub_req", {127'd0, sub_req}, 128'd0);
    chk("rst_dout", dout, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Tied-high handshakes, then a back-to-back block with a different key.
    hs_mode = 0;
    run_block("c1_tied", C1_CT, 0, 1'b0, C1_PT);
    run_block("b_b2b", B_CT, 1, 1'b0, B_PT);
    repeat (2) @(posedge clk);
    #1;

    // Random wait states on both handshakes.
    hs_mode = 1;
    for (int i = 0; i < 3; i++) begin
      run_block("c1_rand", C1_CT, 0, 1'b0, C1_PT);
      @(posedge clk); #1;
    end

    // start hammered while busy.
    run_block("c1_spam", C1_CT, 0, 1'b1, C1_PT);
    @(posedge clk); #1;

    // Abort during the round-5 substitution.
    hs_mode = 0;
    key_sel = 0; din = C1_CT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(sub_req && key_round == 4'd5) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_sub_r5", {127'd0, sub_req && key_round == 4'd5}, 128'd1);
    rst = 1'b1;
    #1;
    chk("abort_ready", {127'd0, ready}, 128'd1);
    chk("abort_dout", dout, 128'd0);
    chk("abort_done", {127'd0, done}, 128'd0);
    chk("abort_sub_req", {127'd0, sub_req}, 128'd0);
    chk("abort_key_req", {127'd0, key_req}, 128'd0);
`ifdef STDAES_INV_ROUND_OUT_EN
    chk("abort_round_vld", {127'd0, round_vld}, 128'd0);
    chk("abort_round_st", round_st, 128'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {127'd0, done}, 128'd0);
    end
    run_block("c1_restart", C1_CT, 0, 1'b0, C1_PT);

    // One more key change under random waits.
    hs_mode = 1;
    run_block("b_rand", B_CT, 1, 1'b0, B_PT);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
